// File: rtl/rvfi_csr_unit.sv
// Zicsr execution unit (CSRRW/S/C and immediate forms) for mcycle and mscratch.
// Produces the RVFI retire trace, including the per-CSR rmask/wmask/rdata/wdata channel.
module rvfi_csr_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_insn,
   input  logic [XLEN-1:0]   in_rs1_rdata,
   output logic              rvfi_valid,
   output logic [63:0]       rvfi_order,
   output logic [31:0]       rvfi_insn,
   output logic              rvfi_trap,
   output logic [4:0]        rvfi_rs1_addr,
   output logic [XLEN-1:0]   rvfi_rs1_rdata,
   output logic [4:0]        rvfi_rd_addr,
   output logic [XLEN-1:0]   rvfi_rd_wdata,
   output logic [XLEN-1:0]   rvfi_csr_mcycle_rmask,
   output logic [XLEN-1:0]   rvfi_csr_mcycle_wmask,
   output logic [XLEN-1:0]   rvfi_csr_mcycle_rdata,
   output logic [XLEN-1:0]   rvfi_csr_mcycle_wdata,
   output logic [XLEN-1:0]   rvfi_csr_mscratch_rmask,
   output logic [XLEN-1:0]   rvfi_csr_mscratch_wmask,
   output logic [XLEN-1:0]   rvfi_csr_mscratch_rdata,
   output logic [XLEN-1:0]   rvfi_csr_mscratch_wdata
);

   localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};

   typedef enum logic {IDLE, EXEC} state_t;

   state_t            state_q, state_d;
   logic              accept;
   logic [31:0]       insn_q;
   logic [XLEN-1:0]   rs1_q;
   logic [XLEN-1:0]   mcycle_q, mcycle_d;
   logic [XLEN-1:0]   mscratch_q, mscratch_d;
   logic [63:0]       order_q;

   // decode / execute signals, valid while in EXEC
   logic [1:0]        f3;
   logic [4:0]        rs1_field, rd_field;
   logic [11:0]       csr_idx;
   logic              sel_mcycle, sel_mscratch, legal, rd_en, wr_en;
   logic [XLEN-1:0]   arg, old_val, new_val;
   logic [XLEN-1:0]   t_rmask, t_wmask, t_rdata, t_wdata, t_rd_wdata;
   logic [4:0]        t_rd_addr;

   // state register
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // instruction decode and CSR read-modify-write
   always_comb begin
      f3           = insn_q[13:12];
      rs1_field    = insn_q[19:15];
      rd_field     = insn_q[11:7];
      csr_idx      = insn_q[31:20];
      sel_mcycle   = (csr_idx == CSR_MCYCLE);
      sel_mscratch = (csr_idx == CSR_MSCRATCH);
      legal        = (insn_q[6:0] == OPC_SYSTEM) && (f3 != 2'd0) &&
                     (sel_mcycle || sel_mscratch);
      arg          = insn_q[14] ? XLEN'(rs1_field) : rs1_q;
      old_val      = sel_mcycle ? mcycle_q : mscratch_q;
      rd_en        = !((f3 == 2'd1) && (rd_field == 5'd0));
      wr_en        = (f3 == 2'd1) || (rs1_field != 5'd0);

      case (f3)
         2'd1:    new_val = arg;
         2'd2:    new_val = old_val | arg;
         2'd3:    new_val = old_val & ~arg;
         default: new_val = '0;
      endcase

      t_rmask    = '0;
      t_wmask    = '0;
      t_rdata    = '0;
      t_wdata    = '0;
      t_rd_addr  = '0;
      t_rd_wdata = '0;
      if (legal) begin
         if (rd_en) begin
            t_rmask = ONES;
            t_rdata = old_val;
         end
         if (wr_en) begin
            t_wmask = ONES;
            t_wdata = new_val;
         end
         t_rd_addr  = rd_field;
         t_rd_wdata = (rd_field != 5'd0) ? old_val : '0;
      end

      // a CSR write to mcycle replaces that cycle's increment
      mcycle_d   = mcycle_q + XLEN'(1);
      mscratch_d = mscratch_q;
      if ((state_q == EXEC) && legal && wr_en) begin
         if (sel_mcycle) mcycle_d   = new_val;
         else            mscratch_d = new_val;
      end
   end

   // datapath registers and RVFI trace outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         in_ready                <= 1'b1;
         insn_q                  <= '0;
         rs1_q                   <= '0;
         mcycle_q                <= '0;
         mscratch_q              <= '0;
         order_q                 <= '0;
         rvfi_valid              <= 1'b0;
         rvfi_order              <= '0;
         rvfi_insn               <= '0;
         rvfi_trap               <= 1'b0;
         rvfi_rs1_addr           <= '0;
         rvfi_rs1_rdata          <= '0;
         rvfi_rd_addr            <= '0;
         rvfi_rd_wdata           <= '0;
         rvfi_csr_mcycle_rmask   <= '0;
         rvfi_csr_mcycle_wmask   <= '0;
         rvfi_csr_mcycle_rdata   <= '0;
         rvfi_csr_mcycle_wdata   <= '0;
         rvfi_csr_mscratch_rmask <= '0;
         rvfi_csr_mscratch_wmask <= '0;
         rvfi_csr_mscratch_rdata <= '0;
         rvfi_csr_mscratch_wdata <= '0;
      end else begin
         in_ready   <= (state_d == IDLE);
         mcycle_q   <= mcycle_d;
         mscratch_q <= mscratch_d;
         rvfi_valid <= 1'b0;
         if (accept) begin
            insn_q <= in_insn;
            rs1_q  <= in_rs1_rdata;
         end
         if (state_q == EXEC) begin
            rvfi_valid              <= 1'b1;
            rvfi_order              <= order_q;
            order_q                 <= order_q + 64'(1);
            rvfi_insn               <= insn_q;
            rvfi_trap               <= !legal;
            rvfi_rs1_addr           <= rs1_field;
            rvfi_rs1_rdata          <= rs1_q;
            rvfi_rd_addr            <= t_rd_addr;
            rvfi_rd_wdata           <= t_rd_wdata;
            rvfi_csr_mcycle_rmask   <= sel_mcycle   ? t_rmask : '0;
            rvfi_csr_mcycle_wmask   <= sel_mcycle   ? t_wmask : '0;
            rvfi_csr_mcycle_rdata   <= sel_mcycle   ? t_rdata : '0;
            rvfi_csr_mcycle_wdata   <= sel_mcycle   ? t_wdata : '0;
            rvfi_csr_mscratch_rmask <= sel_mscratch ? t_rmask : '0;
            rvfi_csr_mscratch_wmask <= sel_mscratch ? t_wmask : '0;
            rvfi_csr_mscratch_rdata <= sel_mscratch ? t_rdata : '0;
            rvfi_csr_mscratch_wdata <= sel_mscratch ? t_wdata : '0;
         end
      end
   end

endmodule

// File: tb/tb_rvfi_csr_unit.sv
// Self-checking bench for rvfi_csr_unit: directed Zicsr cases plus random
// instructions checked against a cycle-indexed architectural model.
module tb_rvfi_csr_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_rs1_rdata;
   logic        rvfi_valid;
   logic [63:0] rvfi_order;
   logic [31:0] rvfi_insn;
   logic        rvfi_trap;
   logic [4:0]  rvfi_rs1_addr;
   logic [31:0] rvfi_rs1_rdata;
   logic [4:0]  rvfi_rd_addr;
   logic [31:0] rvfi_rd_wdata;
   logic [31:0] mc_rmask, mc_wmask, mc_rdata, mc_wdata;
   logic [31:0] ms_rmask, ms_wmask, ms_rdata, ms_wdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // architectural model: mcycle = mc_base + (cycle - mc_epoch)
   logic [31:0] mc_base;
   int          mc_epoch;
   logic [31:0] ms_m;
   logic [63:0] ord_m;
   int          valid_cyc;

   rvfi_csr_unit #(.XLEN(32)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .in_valid                (in_valid),
      .in_ready                (in_ready),
      .in_insn                 (in_insn),
      .in_rs1_rdata            (in_rs1_rdata),
      .rvfi_valid              (rvfi_valid),
      .rvfi_order              (rvfi_order),
      .rvfi_insn               (rvfi_insn),
      .rvfi_trap               (rvfi_trap),
      .rvfi_rs1_addr           (rvfi_rs1_addr),
      .rvfi_rs1_rdata          (rvfi_rs1_rdata),
      .rvfi_rd_addr            (rvfi_rd_addr),
      .rvfi_rd_wdata           (rvfi_rd_wdata),
      .rvfi_csr_mcycle_rmask   (mc_rmask),
      .rvfi_csr_mcycle_wmask   (mc_wmask),
      .rvfi_csr_mcycle_rdata   (mc_rdata),
      .rvfi_csr_mcycle_wdata   (mc_wdata),
      .rvfi_csr_mscratch_rmask (ms_rmask),
      .rvfi_csr_mscratch_wmask (ms_wmask),
      .rvfi_csr_mscratch_rdata (ms_rdata),
      .rvfi_csr_mscratch_wdata (ms_wdata)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [11:0] csr, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] rd);
      return {csr, r1, f3, rd, 7'b1110011};
   endfunction

   // offer one instruction, predict its effect, and check the retire trace
   task automatic run(input logic [31:0] insn, input logic [31:0] rs1v);
      int          n, lat, acc, exec;
      logic [11:0] csr;
      logic [1:0]  f3;
      logic [4:0]  r1, rd;
      logic        legal, is_mc, rden, wren;
      logic [31:0] old, arg, nv;
      logic [31:0] e_rm, e_wm, e_rdat, e_wd, e_rdw;
      logic [4:0]  e_rda;
      n = 0;
      while (in_ready !== 1'b1 && n < 8) begin tick(); n++; end
      chk("in_ready_before_accept", 64'(in_ready), 64'(1));
      in_valid = 1'b1; in_insn = insn; in_rs1_rdata = rs1v;
      acc = cyc;
      tick();
      in_valid = 1'b0; in_insn = $urandom; in_rs1_rdata = $urandom;
      exec = acc + 1;

      csr   = insn[31:20]; f3 = insn[13:12]; r1 = insn[19:15]; rd = insn[11:7];
      is_mc = (csr == 12'hB00);
      legal = (insn[6:0] == 7'h73) && (f3 != 2'd0) && (is_mc || csr == 12'h340);
      old   = is_mc ? mc_base + 32'(exec - mc_epoch) : ms_m;
      arg   = insn[14] ? {27'd0, r1} : rs1v;
      rden  = !(f3 == 2'd1 && rd == 5'd0);
      wren  = (f3 == 2'd1) || (r1 != 5'd0);
      nv    = (f3 == 2'd1) ? arg : (f3 == 2'd2) ? (old | arg) : (old & ~arg);
      e_rm = 0; e_wm = 0; e_rdat = 0; e_wd = 0; e_rda = 0; e_rdw = 0;
      if (legal) begin
         e_rm   = rden ? 32'hFFFF_FFFF : 32'h0;
         e_rdat = rden ? old : 32'h0;
         e_wm   = wren ? 32'hFFFF_FFFF : 32'h0;
         e_wd   = wren ? nv : 32'h0;
         e_rda  = rd;
         e_rdw  = (rd != 5'd0) ? old : 32'h0;
         if (wren) begin
            if (is_mc) begin mc_base = nv; mc_epoch = exec + 1; end
            else ms_m = nv;
         end
      end

      lat = 1;
      while (rvfi_valid !== 1'b1 && lat < 8) begin tick(); lat++; end
      valid_cyc = cyc;
      chk("retire_latency", 64'(lat), 64'(2));
      chk("order", rvfi_order, ord_m);
      ord_m++;
      chk("insn", 64'(rvfi_insn), 64'(insn));
      chk("trap", 64'(rvfi_trap), 64'(!legal));
      chk("rs1_addr", 64'(rvfi_rs1_addr), 64'(r1));
      chk("rs1_rdata", 64'(rvfi_rs1_rdata), 64'(rs1v));
      chk("rd_addr", 64'(rvfi_rd_addr), 64'(e_rda));
      chk("rd_wdata", 64'(rvfi_rd_wdata), 64'(e_rdw));
      chk("mcycle_rmask", 64'(mc_rmask), 64'(is_mc ? e_rm : 32'h0));
      chk("mcycle_wmask", 64'(mc_wmask), 64'(is_mc ? e_wm : 32'h0));
      chk("mcycle_rdata", 64'(mc_rdata), 64'(is_mc ? e_rdat : 32'h0));
      chk("mcycle_wdata", 64'(mc_wdata), 64'(is_mc ? e_wd : 32'h0));
      chk("mscratch_rmask", 64'(ms_rmask), 64'(is_mc ? 32'h0 : e_rm));
      chk("mscratch_wmask", 64'(ms_wmask), 64'(is_mc ? 32'h0 : e_wm));
      chk("mscratch_rdata", 64'(ms_rdata), 64'(is_mc ? 32'h0 : e_rdat));
      chk("mscratch_wdata", 64'(ms_wdata), 64'(is_mc ? 32'h0 : e_wd));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int          v0, v1, v2, gap;
      logic [11:0] rcsr;
      logic [6:0]  ropc;
      logic [31:0] held;

      reset = 1'b1; in_valid = 1'b0; in_insn = '0; in_rs1_rdata = '0;
      tick(); tick();
      mc_base = 0; mc_epoch = cyc; ms_m = 0; ord_m = 0;
      reset = 1'b0;
      chk("reset_in_ready", 64'(in_ready), 64'(1));
      chk("reset_valid", 64'(rvfi_valid), 64'(0));
      chk("reset_order", rvfi_order, 64'(0));
      chk("reset_mscratch_rmask", 64'(ms_rmask), 64'(0));
      chk("reset_rd_addr", 64'(rvfi_rd_addr), 64'(0));

      // CSRRW x5, mscratch, x6 then read back
      run(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEAD_BEEF);
      run(mk(12'h340, 5'd0, 3'b010, 5'd7), 32'h1234_5678);
      // CSRRS x1, mscratch, x0 with mscratch=F0F0
      run(mk(12'h340, 5'd6, 3'b001, 5'd0), 32'h0000_F0F0);
      run(mk(12'h340, 5'd0, 3'b010, 5'd1), 32'hFFFF_FFFF);
      // CSRRCI x2, mscratch, 0x0F with mscratch=FF
      run(mk(12'h340, 5'd6, 3'b001, 5'd0), 32'h0000_00FF);
      run(mk(12'h340, 5'h0F, 3'b111, 5'd2), 32'hAAAA_AAAA);

      // outputs hold after the one-cycle pulse
      held = rvfi_insn;
      tick();
      chk("valid_pulse_drop", 64'(rvfi_valid), 64'(0));
      chk("insn_held", 64'(rvfi_insn), 64'(held));

      // CSRRW x0, mcycle, x3 then read after a gap
      run(mk(12'hB00, 5'd3, 3'b001, 5'd0), 32'h0000_0100);
      repeat (5) tick();
      run(mk(12'hB00, 5'd0, 3'b010, 5'd4), 32'h0);
      // wrap: write all-ones and read on the next slot
      run(mk(12'hB00, 5'd3, 3'b001, 5'd0), 32'hFFFF_FFFF);
      run(mk(12'hB00, 5'd0, 3'b010, 5'd4), 32'h0);

      // illegal: unsupported CSR and f3=0
      run(mk(12'h300, 5'd3, 3'b001, 5'd9), 32'h5555_5555);
      run(mk(12'h340, 5'd3, 3'b000, 5'd9), 32'h5555_5555);

      // reset during EXEC discards the instruction
      while (in_ready !== 1'b1) tick();
      in_valid = 1'b1; in_insn = mk(12'h340, 5'd6, 3'b001, 5'd5); in_rs1_rdata = 32'hCAFE_F00D;
      tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mc_base = 0; mc_epoch = cyc; ms_m = 0; ord_m = 0;
      chk("rst_exec_valid", 64'(rvfi_valid), 64'(0));
      chk("rst_exec_in_ready", 64'(in_ready), 64'(1));
      chk("rst_exec_order", rvfi_order, 64'(0));
      tick();
      chk("rst_exec_no_late_valid", 64'(rvfi_valid), 64'(0));

      // back-to-back orders 0,1,2 at 2-cycle spacing
      run(mk(12'h340, 5'd0, 3'b010, 5'd1), 32'h0);
      v0 = valid_cyc;
      run(mk(12'hB00, 5'd0, 3'b010, 5'd4), 32'h0);
      v1 = valid_cyc;
      run(mk(12'h340, 5'd2, 3'b011, 5'd8), 32'hFFFF_0000);
      v2 = valid_cyc;
      chk("b2b_spacing_01", 64'(v1 - v0), 64'(2));
      chk("b2b_spacing_12", 64'(v2 - v1), 64'(2));

      // random instruction mix
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0, 1:    rcsr = 12'h340;
            2, 3:    rcsr = 12'hB00;
            default: rcsr = 12'($urandom);
         endcase
         ropc = ($urandom_range(0, 9) == 0) ? 7'h33 : 7'h73;
         in_insn = {rcsr, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    3'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), ropc};
         held = in_insn;
         run(held, $urandom);
         gap = $urandom_range(0, 3);
         repeat (gap) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rvfi_csr_unit.md
Name: rvfi_csr_unit

Overview:
Small Zicsr execution unit for the formal test core. It executes CSRRW/CSRRS/CSRRC and their immediate forms against two CSRs: mcycle (0xB00) and mscratch (0x340). For every retired instruction it drives the matching RVFI trace fields, including rd and the per-CSR rmask/wmask/rdata/wdata. It is the producer of the RVFI CSR channel that the CSR-write checks consume.

Parameters:
XLEN, 32, data width of rs1, rd and both CSRs (32 or 64)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  unit can accept an instruction
in_insn  in  32  instruction word
in_rs1_rdata  in  XLEN  rs1 register value
rvfi_valid  out  1  one-cycle retire pulse
rvfi_order  out  64  retire index
rvfi_insn  out  32  retired instruction
rvfi_trap  out  1  illegal instruction
rvfi_rs1_addr  out  5  insn[19:15]
rvfi_rs1_rdata  out  XLEN  captured rs1 value
rvfi_rd_addr  out  5  destination register (0 if no write)
rvfi_rd_wdata  out  XLEN  value written to rd
rvfi_csr_mcycle_rmask / _wmask / _rdata / _wdata  out  XLEN each  mcycle trace
rvfi_csr_mscratch_rmask / _wmask / _rdata / _wdata  out  XLEN each  mscratch trace

Behaviour:
- Reset: state=IDLE, in_ready=1, all rvfi_* outputs=0, rvfi_order=0, mcycle=0, mscratch=0. A reset asserted in any state takes priority and discards any in-flight instruction (no rvfi_valid).
- FSM: IDLE -> EXEC on in_valid&&in_ready. EXEC -> IDLE unconditionally. in_ready = (state==IDLE). Throughput is 1 instruction per 2 cycles.
- Latency: accept in cycle N; CSRs read in cycle N+1 (EXEC) and updated at the end of N+1; rvfi_valid=1 in cycle N+2 only. A new accept is allowed in N+2.
- insn and rs1_rdata are captured on accept. in_insn is ignored when not accepted.
- mcycle increments by 1 every non-reset cycle and wraps modulo 2^XLEN. If EXEC writes mcycle, the next value is wdata with no increment that cycle. rdata is the mcycle value during EXEC.
- Decode:
  - opcode = 1110011.
  - f3 = insn[13:12]; insn[14] selects the immediate form.
  - arg = insn[14] ? zero-extended insn[19:15] : rs1_rdata.
  - Legal iff opcode matches, insn[13:12]!=0, and insn[31:20] is in {0xB00, 0x340}.
- Read (selected CSR):
  - rmask = all-ones, unless f3==1 and rd==0; then rmask=0 and rdata=0.
  - rd_addr = insn[11:7]; rd_wdata = (rd!=0) ? old value : 0.
- Write (selected CSR):
  - f3==1: always writes; wdata = arg.
  - f3==2: writes iff insn[19:15]!=0; wdata = old | arg.
  - f3==3: writes iff insn[19:15]!=0; wdata = old & ~arg.
  - On write: wmask = all-ones. With no write: wmask=0, wdata=0, CSR unchanged.
- Non-selected CSR: all four trace fields are 0.
- Illegal instruction: rvfi_trap=1, no CSR change, all masks/data 0, rd_addr=0, rd_wdata=0. It still retires, and order increments.
- rvfi_order = value before increment; it increments once per retire.
- rvfi_insn upper bits: none (32-bit port), so zero-extension is implicit.
- All rvfi_* outputs hold their last values when rvfi_valid=0. Only rvfi_valid pulses.

Test Plan:
- CSRRW x5, mscratch, x6 with rs1=0xDEADBEEF, mscratch=0 -> rvfi_valid 2 cycles after accept; rd_wdata=0, rmask=FFFFFFFF, wmask=FFFFFFFF, wdata=DEADBEEF; the next read returns DEADBEEF.
- CSRRS x1, mscratch, x0 with mscratch=0x0000F0F0 -> wmask=0, wdata=0, rd_wdata=0000F0F0, mscratch unchanged.
- CSRRCI x2, mscratch, 0x0F with mscratch=0xFF -> rdata=FF, wdata=F0, wmask=all-ones, rd_wdata=FF.
- CSRRW x0, mcycle, x3 with rs1=0x100 accepted at a known cycle -> rmask=0, rdata=0, rd_addr=0; mcycle reads 0x100+k on a CSRRS x4, mcycle, x0 issued k cycles after the write's EXEC cycle; mcycle=FFFFFFFF wraps to 0.
- insn with CSR index 0x300 or f3=0 -> rvfi_trap=1, all CSR masks 0, rd_addr=0, order still increments.
- Reset asserted in the EXEC cycle -> no rvfi_valid, mcycle=0, mscratch=0, in_ready=1 next cycle, order=0; back-to-back accepts give rvfi_order 0,1,2 at 2-cycle spacing.
